// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package rv_fetch_pkg;

   localparam int unsigned INST_BYTES = 4;
   localparam int unsigned XLEN       = 32;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/inst_byte_assembler.sv
// Collects four memory bytes little-endian; byte 3 bypasses the register
// so the full word is available on the same edge that completes it.
module inst_byte_assembler
   import rv_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clear,
   input  logic            i_capture,
   input  logic [7:0]      i_byte,
   output logic [1:0]      o_idx,
   output logic [XLEN-1:0] o_word,
   output logic            o_done
);

   logic [1:0]  r_idx;
   logic [23:0] r_partial;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_partial <= '0;
      end else if (i_clear) begin
         r_idx     <= '0;
         r_partial <= '0;
      end else if (i_capture) begin
         case (r_idx)
            2'd0:    r_partial[7:0]   <= i_byte;
            2'd1:    r_partial[15:8]  <= i_byte;
            2'd2:    r_partial[23:16] <= i_byte;
            default: r_partial        <= r_partial;
         endcase
         r_idx <= r_idx + 2'd1;
      end
   end

   assign o_idx  = r_idx;
   assign o_word = {i_byte, r_partial};
   assign o_done = i_capture && !i_clear && (r_idx == 2'd3);

endmodule

// File: rtl/inst_fetch_unit.sv
// Byte-serial instruction fetch: owns the PC, sequences memory reads and
// hands assembled words to decode over a valid/ready handshake.
module inst_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0]     RESET_PC  = 32'h0000_0000,
   parameter longint unsigned MEM_BYTES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_byte,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_inst_data;
   logic [31:0]  r_inst_pc;
   logic         r_inst_valid;
   logic         r_misalign;

   logic         w_capture;
   logic         w_done;
   logic [1:0]   w_idx;
   logic [31:0]  w_word;
   logic [32:0]  w_pc_plus4;
   logic [31:0]  w_pc_next;

   // fetch_en only gates the start of an instruction; once byte 0 is in, it runs to completion
   assign w_capture  = (r_state == FETCH) && !redirect_valid &&
                       ((w_idx != 2'd0) || fetch_en);
   assign w_pc_plus4 = {1'b0, r_pc} + 33'(INST_BYTES);
   assign w_pc_next  = (w_pc_plus4 == 33'(MEM_BYTES)) ? '0 : w_pc_plus4[31:0];
   assign mem_addr   = r_pc + {30'd0, w_idx};

   inst_byte_assembler u_asm (
      .clk       (clk),
      .rst       (reset),
      .i_clear   (redirect_valid),
      .i_capture (w_capture),
      .i_byte    (mem_byte),
      .o_idx     (w_idx),
      .o_word    (w_word),
      .o_done    (w_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_inst_valid <= 1'b0;
         r_inst_data  <= '0;
         r_inst_pc    <= '0;
         r_misalign   <= 1'b0;
      end else begin
         if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            r_misalign <= 1'b1;

         // A redirect seen in HOLD with inst_ready high still completes that transfer
         if (redirect_valid) begin
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_inst_valid <= 1'b0;
            r_state      <= FETCH;
         end else begin
            case (r_state)
               FETCH: begin
                  if (w_done) begin
                     r_inst_data  <= w_word;
                     r_inst_pc    <= r_pc;
                     r_inst_valid <= 1'b1;
                     r_state      <= HOLD;
                  end
               end
               HOLD: begin
                  if (inst_ready) begin
                     r_inst_valid <= 1'b0;
                     r_pc         <= w_pc_next;
                     r_state      <= FETCH;
                  end
               end
               default: r_state <= FETCH;
            endcase
         end
      end
   end

   assign inst_valid   = r_inst_valid;
   assign inst_data    = r_inst_data;
   assign inst_pc      = r_inst_pc;
   assign misalign_err = r_misalign;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit with a 32-byte instruction memory model.
module tb_inst_fetch_unit;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_en = 1'b0;
   logic [31:0] mem_addr;
   logic [7:0]  mem_byte;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        misalign_err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned n_pushed = 0;
   int unsigned n_popped = 0;
   exp_t        sbq[$];
   exp_t        mon_e;

   logic [7:0]  mem [0:31];
   logic [31:0] prog [8] = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
                             32'h00000013, 32'h00100093, 32'h00208113, 32'h00f768b3};

   always #5 clk = ~clk;

   inst_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .MEM_BYTES (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .mem_addr       (mem_addr),
      .mem_byte       (mem_byte),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .misalign_err   (misalign_err)
   );

   always_comb mem_byte = (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 8'h00;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [31:0] p);
      exp_t e;
      e.data = d;
      e.pc   = p;
      sbq.push_back(e);
      n_pushed++;
   endtask

   // Monitor: every accepted instruction is compared against the queue head
   always @(negedge clk) begin
      if (!reset && inst_valid && inst_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst actual data=0x%08h pc=0x%08h expected none", inst_data, inst_pc);
         end else begin
            mon_e = sbq.pop_front();
            check32("inst_data", inst_data, mon_e.data);
            check32("inst_pc", inst_pc, mon_e.pc);
         end
         n_popped++;
      end
   end

   task automatic drain();
      int unsigned k = 0;
      while (n_popped != n_pushed && k < 300) begin
         @(posedge clk); #2;
         k++;
      end
      if (n_popped != n_pushed) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d expected=%0d", n_popped, n_pushed);
      end
      fetch_en = 1'b0;
   endtask

   task automatic wait_valid();
      int unsigned k = 0;
      @(negedge clk);
      while (!inst_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      check32("wait_valid", {31'd0, inst_valid}, 32'd1);
   endtask

   task automatic wait_addr(input logic [31:0] a);
      int unsigned k = 0;
      @(negedge clk);
      while (mem_addr != a && k < 30) begin
         @(negedge clk);
         k++;
      end
      check32("wait_addr", mem_addr, a);
   endtask

   task automatic do_reset(input logic en, input logic rdy);
      @(posedge clk); #2;
      reset = 1'b1;
      redirect_valid = 1'b0;
      fetch_en = en;
      inst_ready = rdy;
      @(posedge clk); #2;
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check32({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
      check32({tag, "_data"}, inst_data, 32'd0);
      check32({tag, "_pc"}, inst_pc, 32'd0);
      check32({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
      check32({tag, "_mem_addr"}, mem_addr, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_addr [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd4, 32'd5, 32'd6, 32'd7};
      logic        exp_v    [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int unsigned w = 0; w < 8; w++) begin
         mem[4*w]   = prog[w][7:0];
         mem[4*w+1] = prog[w][15:8];
         mem[4*w+2] = prog[w][23:16];
         mem[4*w+3] = prog[w][31:24];
      end

      // Reset values, then latency and address sequence with ready tied high
      fetch_en = 1'b1;
      inst_ready = 1'b1;
      #1 reset = 1'b1;
      #1 check_reset_outputs("rst0");
      push(prog[0], 32'd0);
      push(prog[1], 32'd4);
      @(posedge clk); #2;
      reset = 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
         @(negedge clk);
         check32("seq_mem_addr", mem_addr, exp_addr[i]);
         check32("seq_valid", {31'd0, inst_valid}, {31'd0, exp_v[i]});
      end
      drain();

      // Backpressure: held instruction stays stable, no new fetch
      do_reset(1'b1, 1'b0);
      push(prog[0], 32'd0);
      wait_valid();
      for (int unsigned i = 0; i < 10; i++) begin
         check32("hold_data", inst_data, prog[0]);
         check32("hold_pc", inst_pc, 32'd0);
         check32("hold_mem_addr", mem_addr, 32'd0);
         check32("hold_valid", {31'd0, inst_valid}, 32'd1);
         @(negedge clk);
      end
      @(posedge clk); #2;
      inst_ready = 1'b1;
      push(prog[1], 32'd4);
      @(negedge clk);
      @(negedge clk);
      check32("after_hold_mem_addr", mem_addr, 32'd4);
      check32("after_hold_valid", {31'd0, inst_valid}, 32'd0);
      drain();

      // Wrap at end of memory
      do_reset(1'b1, 1'b1);
      for (int unsigned w = 0; w < 8; w++) push(prog[w], 32'(4*w));
      push(prog[0], 32'd0);
      drain();

      // Redirect during byte 2 of the fetch at 4
      do_reset(1'b1, 1'b1);
      push(prog[0], 32'd0);
      wait_addr(32'd6);
      redirect_valid = 1'b1;
      redirect_pc = 32'd12;
      push(prog[3], 32'd12);
      @(posedge clk); #2;
      redirect_valid = 1'b0;
      @(negedge clk);
      check32("redir_mem_addr", mem_addr, 32'd12);
      check32("redir_misalign", {31'd0, misalign_err}, 32'd0);
      drain();

      // Misaligned redirect, then redirect coinciding with a handshake
      @(posedge clk); #2;
      inst_ready = 1'b0;
      fetch_en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0009;
      push(prog[2], 32'd8);
      @(posedge clk); #2;
      redirect_valid = 1'b0;
      @(negedge clk);
      check32("misalign_set", {31'd0, misalign_err}, 32'd1);
      check32("misalign_mem_addr", mem_addr, 32'd8);
      wait_valid();
      @(posedge clk); #2;
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'd12;
      push(prog[3], 32'd12);
      @(posedge clk); #2;
      redirect_valid = 1'b0;
      @(negedge clk);
      check32("hs_redir_valid", {31'd0, inst_valid}, 32'd0);
      check32("hs_redir_mem_addr", mem_addr, 32'd12);
      drain();
      check32("misalign_sticky", {31'd0, misalign_err}, 32'd1);

      // Asynchronous reset mid-assembly
      @(posedge clk); #2;
      fetch_en = 1'b1;
      wait_addr(32'd18);
      reset = 1'b1;
      #1 check_reset_outputs("rst_mid");
      @(posedge clk); #2;
      reset = 1'b0;
      push(prog[0], 32'd0);
      drain();

      check32("scoreboard_empty", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
